// File: rtl/eth_rx_pkg.sv
// rtl/eth_rx_pkg.sv - shared widths and types for the Ethernet Rx command path
package eth_rx_pkg;

    localparam int CMD_LEN       = 32;
    localparam int NCHAN         = 8;
    localparam int CHAN_W        = 3;
    localparam int BYTES_PER_CMD = CMD_LEN / 8;
    localparam int BCNT_W        = (BYTES_PER_CMD > 1) ? $clog2(BYTES_PER_CMD) : 1;

    typedef logic [CHAN_W-1:0] chan_t;
    typedef logic [BCNT_W-1:0] bcnt_t;

    localparam bcnt_t BCNT_LAST = bcnt_t'(BYTES_PER_CMD - 1);

    typedef struct packed {
        logic [CMD_LEN-1:0] data;
        chan_t              channel;
    } cmd_word_t;

endpackage

// File: rtl/ethernet_rx_controller_if.sv
// rtl/ethernet_rx_controller_if.sv - GigEx Rx byte stream plus assembled command word handshake
interface ethernet_rx_controller_if;
    import eth_rx_pkg::*;

    logic [7:0]         byte_in;
    logic               byte_in_valid;
    chan_t              byte_channel;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [CMD_LEN-1:0] cmd_data;
    chan_t              cmd_channel;

    modport master (
        output byte_in, byte_in_valid, byte_channel, cmd_ready,
        input  cmd_valid, cmd_data, cmd_channel
    );

    modport slave (
        input  byte_in, byte_in_valid, byte_channel, cmd_ready,
        output cmd_valid, cmd_data, cmd_channel
    );

endinterface

// File: rtl/eth_rx_word_fifo.sv
// rtl/eth_rx_word_fifo.sv - first-word-fall-through FIFO of tagged command words
module eth_rx_word_fifo
    import eth_rx_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  cmd_word_t                wdata_i,
    input  logic                     pop_i,
    output cmd_word_t                rdata_o,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    cmd_word_t       mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            wr_en, rd_en;

    // A write into a full FIFO is allowed only when a read frees the slot in the same cycle.
    always_comb begin
        rd_en    = pop_i && (count_q != '0);
        wr_en    = push_i && ((count_q != (AW+1)'(DEPTH)) || rd_en);
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (wr_en && !rd_en) begin
            count_d = count_q + 1'b1;
        end else if (rd_en && !wr_en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o     = mem_q[rd_ptr_q];
    assign occupancy_o = count_q;
    assign full_o      = (count_q == (AW+1)'(DEPTH));
    assign empty_o     = (count_q == '0);

endmodule

// File: rtl/ethernet_rx_controller.sv
// rtl/ethernet_rx_controller.sv - per-channel byte-to-word packer with buffered output and nRF backpressure
// Optional partial-word idle timeout enabled by defining ETH_RX_TIMEOUT_EN.
module ethernet_rx_controller
    import eth_rx_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int FULL_MARGIN = 2
`ifdef ETH_RX_TIMEOUT_EN
    ,
    parameter int TIMEOUT     = 1024
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    ethernet_rx_controller_if.slave    bus,
    output logic [NCHAN-1:0]           channel_full,
    output logic                       overflow,
    output logic [15:0]                drop_count
);

    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
    typedef logic [OCC_W-1:0] occ_t;
    localparam occ_t FULL_THRESH = occ_t'(FIFO_DEPTH - FULL_MARGIN);

    // Only the bytes preceding the newest one need storing; the newest comes straight from byte_in.
    logic [CMD_LEN-9:0] shift_q [NCHAN];
    bcnt_t              cnt_q   [NCHAN];

    chan_t              ch;
    logic               accept, last_byte, pop, drop, timeout_clr;
    logic [CMD_LEN-1:0] word;
    cmd_word_t          push_word, head;
    occ_t               occupancy;
    logic               fifo_full, fifo_empty;

    logic [NCHAN-1:0]   full_q, full_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;

    always_comb begin
        ch        = bus.byte_channel;
        accept    = bus.byte_in_valid;
        word      = {shift_q[ch], bus.byte_in};
        last_byte = accept && (cnt_q[ch] == BCNT_LAST);
        pop       = !fifo_empty && bus.cmd_ready;
        drop      = last_byte && fifo_full && !pop;
        push_word = '{data: word, channel: ch};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCHAN; i++) begin
                shift_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            if (timeout_clr) begin
                for (int i = 0; i < NCHAN; i++) begin
                    cnt_q[i] <= '0;
                end
            end
            if (accept) begin
                shift_q[ch] <= word[CMD_LEN-9:0];
                cnt_q[ch]   <= last_byte ? '0 : cnt_q[ch] + 1'b1;
            end
        end
    end

`ifdef ETH_RX_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT) + 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT - 1);

    logic [IDLE_W-1:0] idle_q;

    // Saturates at IDLE_MAX so the clear keeps asserting until traffic resumes.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            idle_q <= '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_q <= idle_q + 1'b1;
        end
    end

    assign timeout_clr = !accept && (idle_q == IDLE_MAX);
`else
    assign timeout_clr = 1'b0;
`endif

    eth_rx_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (last_byte),
        .wdata_i     (push_word),
        .pop_i       (bus.cmd_ready),
        .rdata_o     (head),
        .occupancy_o (occupancy),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        full_d     = {NCHAN{occupancy >= FULL_THRESH}};
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q     <= '1;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            full_q     <= full_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.cmd_valid   = !fifo_empty;
    assign bus.cmd_data    = fifo_empty ? '0 : head.data;
    assign bus.cmd_channel = fifo_empty ? '0 : head.channel;
    assign channel_full    = full_q;
    assign overflow        = overflow_q;
    assign drop_count      = drop_cnt_q;

endmodule
